// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the two-requester memory access controller:
// FSM state encoding, requester identifiers and the data width.
package mem_access_ctrl_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/mem_access_ctrl_arb.sv
// Two-way round-robin arbiter. The requester named by last_i was served
// most recently and therefore loses a tie; a lone request always wins.
module rr_arbiter_2
  import mem_access_ctrl_pkg::*;
(
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  // Combinational winner selection
  always_comb begin
    gnt_valid_o = req_a_i | req_b_i;
    gnt_id_o    = REQ_A;
    if (req_a_i && req_b_i) begin
      if (last_i == REQ_A) begin
        gnt_id_o = REQ_B;
      end else begin
        gnt_id_o = REQ_A;
      end
    end else if (req_b_i) begin
      gnt_id_o = REQ_B;
    end else begin
      gnt_id_o = REQ_A;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates two requesters onto a single
// 2**N x 2**N byte array. One transaction is IDLE -> ACCESS -> RESP;
// all outputs come straight from registers.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [2*N-1:0]    a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [2*N-1:0]    b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [N-1:0]      mem_row,
  output logic [N-1:0]      mem_col,
  output logic              mem_Rd,
  output logic              mem_Wr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                last_q, last_d;      // last-served requester
  logic                id_q, id_d;          // requester owning the current op
  logic                wr_q, wr_d;          // latched operation type
  logic [N-1:0]        row_q, row_d;        // latched row (drives mem_row)
  logic [N-1:0]        col_q, col_d;        // latched column (drives mem_col)
  logic [DATA_W-1:0]   din_q, din_d;        // latched write data
  logic                rd_q, rd_d;
  logic                wrs_q, wrs_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                busy_q, busy_d;

  logic                gnt_valid;
  logic                gnt_id;
  logic                sel_wr;
  logic [2*N-1:0]      sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_arbiter_2 u_arb (
    .req_a_i     (a_req),
    .req_b_i     (b_req),
    .last_i      (last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  // Route the granted requester's operation fields
  always_comb begin
    if (gnt_id == REQ_B) begin
      sel_wr    = b_wr;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end else begin
      sel_wr    = a_wr;
      sel_addr  = a_addr;
      sel_wdata = a_wdata;
    end
  end

  // Next-state and next-output logic; strobes and acks default low
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    wr_d      = wr_q;
    row_d     = row_q;
    col_d     = col_q;
    din_d     = din_q;
    rd_d      = 1'b0;
    wrs_d     = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          // Latch the winner's request; the strobes become active with ACCESS
          state_d = ACCESS;
          id_d    = gnt_id;
          wr_d    = sel_wr;
          row_d   = sel_addr[2*N-1:N];
          col_d   = sel_addr[N-1:0];
          din_d   = sel_wdata;
          wrs_d   = sel_wr;
          rd_d    = ~sel_wr;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // Capture array read data at the end of the strobe cycle
        state_d = RESP;
        if (!wr_q) begin
          if (id_q == REQ_B) begin
            b_rdata_d = mem_data_out;
          end else begin
            a_rdata_d = mem_data_out;
          end
        end else begin
          a_rdata_d = a_rdata_q;
        end
        if (id_q == REQ_B) begin
          b_ack_d = 1'b1;
        end else begin
          a_ack_d = 1'b1;
        end
      end
      RESP: begin
        // The pointer moves only once the ack has been delivered
        state_d = IDLE;
        last_d  = id_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; last_q resets to B so A wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= REQ_B;
      id_q      <= REQ_A;
      wr_q      <= 1'b0;
      row_q     <= {N{1'b0}};
      col_q     <= {N{1'b0}};
      din_q     <= {DATA_W{1'b0}};
      rd_q      <= 1'b0;
      wrs_q     <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= {DATA_W{1'b0}};
      b_rdata_q <= {DATA_W{1'b0}};
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      wr_q      <= wr_d;
      row_q     <= row_d;
      col_q     <= col_d;
      din_q     <= din_d;
      rd_q      <= rd_d;
      wrs_q     <= wrs_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign mem_row     = row_q;
  assign mem_col     = col_q;
  assign mem_data_in = din_q;
  assign mem_Rd      = rd_q;
  assign mem_Wr      = wrs_q;
  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign busy        = busy_q;

endmodule
